alu_rr_sched: RTL and testbench
===============================

Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one combinational ALU (A, B, 4-bit opcode, en, result) among N requester ports.
- Each requester issues an operation with a valid/ready handshake and gets its result back on a dedicated response handshake.
- Sits between multiple issue sources and the single ALU instance; one operation in flight at a time.

Parameters:
- N_REQ, 4, number of requester ports (2..8).
- WIDTH, 32, operand/result width; must match the ALU instance.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req_valid  input  N_REQ  per-requester operation valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- req_a  input  N_REQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  input  N_REQ*WIDTH  operand B, same packing.
- req_op  input  N_REQ*4  opcode, same packing.
- rsp_valid  output  N_REQ  response valid to the owning requester; at most one bit high.
- rsp_ready  input  N_REQ  per-requester response accept.
- rsp_data  output  WIDTH  result, shared bus, qualified by rsp_valid.
- rsp_err  output  1  illegal-opcode flag, qualified by rsp_valid; see Optional Feature.
- alu_a, alu_b  output  WIDTH  operands to the ALU.
- alu_opcode  output  4  opcode to the ALU.
- alu_en  output  1  ALU enable.
- alu_result  input  WIDTH  combinational result from the ALU.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst_n=0), effective immediately regardless of state:
  - state=IDLE, rr_ptr=0, all operand/opcode/owner/result registers cleared.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, alu_en=0, alu_a/alu_b/alu_opcode=0.
  - Reset mid-EXEC/RESP drops the in-flight operation; no response is ever produced for it.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at N_REQ-1 -> 0.
  - req_ready is one-hot to the granted index, combinational from req_valid in IDLE only; it is 0 in all other states.
  - On handshake, register a/b/op and owner index, set rr_ptr = (grant+1) mod N_REQ, go to EXEC.
  - No valid requester: stay in IDLE; rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - Drive alu_a/alu_b/alu_opcode from registers with alu_en=1.
  - Capture alu_result into the result register at the clock edge, then go to RESP.
  - alu_en=0 and ALU inputs=0 in every other state.
- RESP:
  - rsp_valid[owner]=1, rsp_data=result register.
  - Hold both stable until rsp_ready[owner]=1, then go to IDLE.
  - rsp_ready on non-owner bits is ignored.
  - The next request can be accepted no earlier than the cycle after the response handshake.
- Latency:
  - Request handshake at edge t; rsp_valid high from t+2.
  - Throughput: one operation per 3 cycles when rsp_ready is tied high.
- Requesters must hold req_* stable while valid and unaccepted; the scheduler does not check this.
- Simultaneous requests: only the granted requester sees ready; the others wait with no loss of state.
- Opcode is forwarded unmodified. The ALU returns 0 for unknown opcodes and that value is passed through unchanged.

Optional Feature:
- Macro: ALU_RR_SCHED_OPCHK_EN.
- Defined: legal opcodes are 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100.
  - An illegal opcode is still accepted normally.
  - EXEC runs with alu_en=0.
  - RESP returns rsp_data=0 and rsp_err=1 under the same handshake timing.
  - Legal opcodes return rsp_err=0.
- Undefined: no opcode decoding; rsp_err is tied to 0; all opcodes execute with alu_en=1.

Test Plan:
- Reset/idle: assert rst_n=0 mid-EXEC with requester 1 granted -> all outputs 0 immediately; after release, no rsp_valid appears and rr_ptr=0.
- Single ADD: requester 2 sends A=0x0000_0005, B=0x0000_0003, op=0000 with rsp_ready=1 -> req_ready[2] at t; alu_en=1 with those operands at t+1; rsp_valid[2]=1 with rsp_data=0x0000_0008 at t+2.
- Round-robin fairness: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0; each response on the matching rsp_valid bit; grants spaced 3 cycles apart.
- Backpressure: requester 0 sends SUB A=0, B=1; hold rsp_ready[0]=0 for 5 cycles while requester 1 is valid -> rsp_data stays 0xFFFF_FFFF; req_ready[1]=0 throughout; requester 1 is granted the cycle after rsp_ready[0]=1.
- Wrap-around: rr_ptr=3 and only req_valid[1]=1 -> grant 1, then rr_ptr=2; next simultaneous valid on 0 and 2 -> grant 2.
- Opcode check: op=4'b1111 from requester 3 -> with ALU_RR_SCHED_OPCHK_EN, alu_en=0, rsp_data=0 and rsp_err=1; without it, alu_en=1 and rsp_err=0.

Source files
------------

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU among N_REQ requesters.
// Optional opcode legality check: define ALU_RR_SCHED_OPCHK_EN.
module alu_rr_sched #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*4-1:0]     req_op,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_err,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic [3:0]             alu_opcode,
   output logic                   alu_en,
   input  logic [WIDTH-1:0]       alu_result
);

   // state  | meaning
   // IDLE   | arbitrating; req_ready one-hot to the granted requester
   // EXEC   | ALU driven from captured operands, result captured at edge
   // RESP   | response held on owner's rsp_valid until rsp_ready[owner]
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    owner_q,  owner_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic [3:0]       op_q,     op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q,    err_d;

   logic             gnt_found;
   logic [IW-1:0]    gnt_idx;
   logic [WIDTH-1:0] gnt_a;
   logic [WIDTH-1:0] gnt_b;
   logic [3:0]       gnt_op;
   logic             rsp_hs;
   logic             illegal_op;

`ifdef ALU_RR_SCHED_OPCHK_EN
   assign illegal_op = (op_q > 4'd4);
`else
   assign illegal_op = 1'b0;
`endif

   // First pass covers indices at/above the pointer, second pass the wrap.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_a     = '0;
      gnt_b     = '0;
      gnt_op    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!gnt_found && req_valid[i] && (IW'(i) >= rr_ptr_q)) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'(i);
            gnt_a     = req_a[i*WIDTH +: WIDTH];
            gnt_b     = req_b[i*WIDTH +: WIDTH];
            gnt_op    = req_op[i*4 +: 4];
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!gnt_found && req_valid[i]) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'(i);
            gnt_a     = req_a[i*WIDTH +: WIDTH];
            gnt_b     = req_b[i*WIDTH +: WIDTH];
            gnt_op    = req_op[i*4 +: 4];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = (state_q == S_IDLE) && gnt_found && (gnt_idx == IW'(i));
         rsp_valid[i] = (state_q == S_RESP) && (owner_q == IW'(i));
      end
   end

   assign rsp_hs     = |(rsp_valid & rsp_ready);
   assign rsp_data   = result_q;
   assign rsp_err    = err_q;
   assign alu_en     = (state_q == S_EXEC) && !illegal_op;
   assign alu_a      = (state_q == S_EXEC) ? a_q  : '0;
   assign alu_b      = (state_q == S_EXEC) ? b_q  : '0;
   assign alu_opcode = (state_q == S_EXEC) ? op_q : '0;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               owner_d  = gnt_idx;
               a_d      = gnt_a;
               b_d      = gnt_b;
               op_d     = gnt_op;
               rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = illegal_op ? '0 : alu_result;
            err_d    = illegal_op;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (rsp_hs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched with a behavioural ALU attached.
module tb_alu_rr_sched;
   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N*4-1:0] req_op = '0;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready = '1;
   logic [W-1:0]   rsp_data;
   logic           rsp_err;
   logic [W-1:0]   alu_a, alu_b, alu_result;
   logic [3:0]     alu_opcode;
   logic           alu_en;

   typedef struct {
      int           owner;
      logic [W-1:0] data;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_rr_sched #(.N_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_en(alu_en), .alu_result(alu_result)
   );

   function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return '0;
      endcase
   endfunction

   always_comb alu_result = alu_en ? alu_f(alu_opcode, alu_a, alu_b) : '0;

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_op[i*4 +: 4] = op;
   endtask

   task automatic push_exp(input int i);
      exp_t e;
      logic [3:0] op;
      op      = req_op[i*4 +: 4];
      e.owner = i;
      e.data  = alu_f(op, req_a[i*W +: W], req_b[i*W +: W]);
      e.err   = 1'b0;
`ifdef ALU_RR_SCHED_OPCHK_EN
      if (op > 4'd4) begin
         e.data = '0;
         e.err  = 1'b1;
      end
`endif
      sb.push_back(e);
   endtask

   // One isolated transaction with rsp_ready all high; checks grant, EXEC and response.
   task automatic txn(input int g, input logic [N-1:0] valids, input logic exp_en, input string nm);
      exp_t e;
      @(negedge clk);
      req_valid = valids;
      push_exp(g);
      #1;
      n_vec++;
      if (req_ready !== N'(1 << g)) begin
         n_err++;
         $display("FAIL %s grant: req_ready=%b expected %b", nm, req_ready, N'(1 << g));
      end
      @(negedge clk);
      req_valid = '0;
      n_vec++;
      if (alu_en !== exp_en || alu_opcode !== req_op[g*4 +: 4]) begin
         n_err++;
         $display("FAIL %s exec: alu_en=%b op=%h expected en=%b op=%h", nm, alu_en, alu_opcode, exp_en, req_op[g*4 +: 4]);
      end
      @(negedge clk);
      n_vec++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL %s rsp: scoreboard empty, rsp_valid=%b", nm, rsp_valid);
      end else begin
         e = sb.pop_front();
         if (rsp_valid !== N'(1 << e.owner) || rsp_data !== e.data || rsp_err !== e.err) begin
            n_err++;
            $display("FAIL %s rsp: valid=%b data=%h err=%b expected valid=%b data=%h err=%b",
                     nm, rsp_valid, rsp_data, rsp_err, N'(1 << e.owner), e.data, e.err);
         end
      end
   endtask

   task automatic test_reset;
      logic seen;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({req_ready, rsp_valid, rsp_data, rsp_err, alu_en, alu_a, alu_b, alu_opcode} !== '0) begin
         n_err++;
         $display("FAIL reset_outs: ready=%b rsp_valid=%b data=%h err=%b en=%b a=%h b=%h op=%h expected all 0",
                  req_ready, rsp_valid, rsp_data, rsp_err, alu_en, alu_a, alu_b, alu_opcode);
      end
      rst_n = 1'b1;
      set_req(1, 32'h11, 32'h22, 4'd0);
      req_valid = 4'b0010;
      #1;
      n_vec++;
      if (req_ready !== 4'b0010) begin
         n_err++;
         $display("FAIL reset_pre_grant: req_ready=%b expected 0010", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      n_vec++;
      if (alu_en !== 1'b1) begin
         n_err++;
         $display("FAIL reset_pre_exec: alu_en=%b expected 1", alu_en);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({req_ready, rsp_valid, rsp_data, rsp_err, alu_en, alu_a, alu_b, alu_opcode} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_exec: ready=%b rsp_valid=%b data=%h err=%b en=%b a=%h b=%h op=%h expected all 0",
                  req_ready, rsp_valid, rsp_data, rsp_err, alu_en, alu_a, alu_b, alu_opcode);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid !== '0) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL reset_no_rsp: rsp_valid seen=%b expected 0", seen);
      end
      req_valid = 4'b1111;
      #1;
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL reset_ptr: req_ready=%b expected 0001", req_ready);
      end
      req_valid = '0;
   endtask

   task automatic test_single_add;
      exp_t e;
      @(negedge clk);
      set_req(2, 32'h0000_0005, 32'h0000_0003, 4'd0);
      req_valid = 4'b0100;
      push_exp(2);
      #1;
      n_vec++;
      if (req_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL add_grant: req_ready=%b expected 0100", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      n_vec++;
      if (alu_en !== 1'b1 || alu_a !== 32'h5 || alu_b !== 32'h3 || alu_opcode !== 4'd0 || req_ready !== '0) begin
         n_err++;
         $display("FAIL add_exec: en=%b a=%h b=%h op=%h ready=%b expected 1/5/3/0/0000",
                  alu_en, alu_a, alu_b, alu_opcode, req_ready);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 32'h0000_0008 || e.data !== 32'h8 || rsp_err !== 1'b0) begin
         n_err++;
         $display("FAIL add_rsp: valid=%b data=%h err=%b expected 0100/00000008/0", rsp_valid, rsp_data, rsp_err);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== '0 || alu_en !== 1'b0) begin
         n_err++;
         $display("FAIL add_idle: rsp_valid=%b alu_en=%b expected 0000/0", rsp_valid, alu_en);
      end
   endtask

   task automatic test_round_robin;
      int   grants[$];
      int   gcyc[$];
      int   order[5] = '{0, 1, 2, 3, 0};
      exp_t e;
      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 32'h1000 * (i + 1) + i, 32'(i + 7), 4'(i));
      rsp_ready = '1;
      req_valid = 4'b1111;
      for (int c = 0; c < 40 && (grants.size() < 5 || sb.size() > 0); c++) begin
         if (grants.size() == 5) req_valid = '0;
         #1;
         if (rsp_valid !== '0) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL rr_rsp: unexpected rsp_valid=%b", rsp_valid);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== N'(1 << e.owner) || rsp_data !== e.data) begin
                  n_err++;
                  $display("FAIL rr_rsp: valid=%b data=%h expected %b/%h", rsp_valid, rsp_data, N'(1 << e.owner), e.data);
               end
            end
         end
         if (req_ready !== '0) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) begin
               grants.push_back(i);
               gcyc.push_back(c);
               push_exp(i);
            end
         end
         @(negedge clk);
      end
      req_valid = '0;
      n_vec++;
      if (grants.size() != 5 || sb.size() != 0) begin
         n_err++;
         $display("FAIL rr_timeout: grants=%0d pending=%0d expected 5/0", grants.size(), sb.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (grants[k] != order[k] || (k > 0 && gcyc[k] - gcyc[k-1] != 3)) begin
               n_err++;
               $display("FAIL rr_order[%0d]: grant=%0d gap=%0d expected %0d/3", k, grants[k],
                        (k > 0) ? gcyc[k] - gcyc[k-1] : 3, order[k]);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      exp_t e;
      @(negedge clk);
      rsp_ready = '0;
      set_req(0, 32'h0, 32'h1, 4'd1);
      req_valid = 4'b0001;
      push_exp(0);
      #1;
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL bp_grant0: req_ready=%b expected 0001", req_ready);
      end
      @(negedge clk);
      set_req(1, 32'h20, 32'h22, 4'd0);
      req_valid = 4'b0010;
      #1;
      n_vec++;
      if (req_ready !== '0) begin
         n_err++;
         $display("FAIL bp_exec_ready: req_ready=%b expected 0000", req_ready);
      end
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         rsp_ready = 4'b1110;
         #1;
         n_vec++;
         if (rsp_valid !== 4'b0001 || rsp_data !== 32'hFFFF_FFFF || req_ready !== '0) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b expected 0001/ffffffff/0000", k, rsp_valid, rsp_data, req_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 4'b0001;
      #1;
      e = sb.pop_front();
      n_vec++;
      if (rsp_valid !== 4'b0001 || rsp_data !== e.data) begin
         n_err++;
         $display("FAIL bp_rsp0: valid=%b data=%h expected 0001/%h", rsp_valid, rsp_data, e.data);
      end
      @(negedge clk);
      rsp_ready = '1;
      #1;
      n_vec++;
      if (req_ready !== 4'b0010) begin
         n_err++;
         $display("FAIL bp_grant1: req_ready=%b expected 0010", req_ready);
      end
      push_exp(1);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (rsp_valid !== 4'b0010 || rsp_data !== e.data) begin
         n_err++;
         $display("FAIL bp_rsp1: valid=%b data=%h expected 0010/%h", rsp_valid, rsp_data, e.data);
      end
   endtask

   task automatic test_wrap;
      set_req(2, 32'h0F0F, 32'h00FF, 4'd2);
      txn(2, 4'b0100, 1'b1, "wrap_pre");
      set_req(1, 32'h100, 32'h011, 4'd3);
      txn(1, 4'b0010, 1'b1, "wrap_grant1");
      set_req(0, 32'hAAAA, 32'h5555, 4'd4);
      txn(2, 4'b0101, 1'b1, "wrap_grant2");
   endtask

   task automatic test_opcheck;
`ifdef ALU_RR_SCHED_OPCHK_EN
      logic exp_en = 1'b0;
`else
      logic exp_en = 1'b1;
`endif
      set_req(3, 32'h1234, 32'h4321, 4'hF);
      txn(3, 4'b1000, exp_en, "opchk_illegal");
      set_req(0, 32'hFF00, 32'h0FF0, 4'd4);
      txn(0, 4'b0001, 1'b1, "opchk_legal");
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_opcheck();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
